// File: rtl/tetris_display_scan.sv
// rtl/tetris_display_scan.sv - row-multiplexed LED matrix scanner for the 20x10 playfield
// A frame snapshot is taken in SNAP so playfield updates mid-frame never tear the image.
module tetris_display_scan #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int DWELL = 1000,
    parameter int BLANK = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [ROWS-1:0][COLS-1:0] screen,
    output logic [4:0]                row_sel,
    output logic                      row_en,
    output logic [COLS-1:0]           col_data,
    output logic                      frame_done
);

    localparam int CMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        ST_SNAP  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [CW-1:0]             r_cnt;
    logic [CW-1:0]             w_next_cnt;
    logic [4:0]                r_row_sel;
    logic [4:0]                w_next_row;
    logic                      r_row_en;
    logic [COLS-1:0]           r_col_data;
    logic [COLS-1:0]           w_next_col;
    logic                      r_frame_done;
    logic [ROWS-1:0][COLS-1:0] r_shadow;

    // r_frame_done low while in SNAP marks the reset-entered state: hold one more
    // cycle so every real snapshot cycle is flagged with frame_done.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_row   = r_row_sel;
        case (r_state)
            ST_SNAP: begin
                w_next_cnt = '0;
                w_next_row = '0;
                if (r_frame_done && enable) begin
                    w_next_state = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    w_next_state = ST_SNAP;
                    w_next_cnt   = '0;
                    w_next_row   = '0;
                end else if (r_cnt == CW'(BLANK - 1)) begin
                    w_next_state = ST_DRIVE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            ST_DRIVE: begin
                if (!enable) begin
                    w_next_state = ST_SNAP;
                    w_next_cnt   = '0;
                    w_next_row   = '0;
                end else if (r_cnt == CW'(DWELL - 1)) begin
                    w_next_cnt = '0;
                    if (r_row_sel == 5'(ROWS - 1)) begin
                        w_next_state = ST_SNAP;
                        w_next_row   = '0;
                    end else begin
                        w_next_state = ST_BLANK;
                        w_next_row   = r_row_sel + 5'd1;
                    end
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_next_state = ST_SNAP;
                w_next_cnt   = '0;
                w_next_row   = '0;
            end
        endcase
    end

    assign w_next_col = (w_next_state == ST_DRIVE) ? r_shadow[w_next_row] : '0;

    // Outputs are registered from the next state so they move with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SNAP;
            r_cnt        <= '0;
            r_row_sel    <= '0;
            r_row_en     <= 1'b0;
            r_col_data   <= '0;
            r_frame_done <= 1'b0;
            r_shadow     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_row_sel    <= w_next_row;
            r_row_en     <= (w_next_state == ST_DRIVE);
            r_col_data   <= w_next_col;
            r_frame_done <= (w_next_state == ST_SNAP);
            if (r_state == ST_SNAP) begin
                r_shadow <= screen;
            end
        end
    end

    assign row_sel    = r_row_sel;
    assign row_en     = r_row_en;
    assign col_data   = r_col_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_tetris_display_scan.sv
// tb/tb_tetris_display_scan.sv - self-checking bench for tetris_display_scan
module tb_tetris_display_scan;

    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int A_D   = 4;
    localparam int A_B   = 1;
    localparam int A_PER = ROWS * (A_D + A_B) + 1;
    localparam int B_D   = 1000;
    localparam int B_B   = 2;
    localparam int B_PER = ROWS * (B_D + B_B) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_a, en_a, ren_a, fd_a;
    logic [ROWS-1:0][COLS-1:0] scr_a;
    logic [4:0]                rs_a;
    logic [COLS-1:0]           col_a;
    logic                      rst_b, en_b, ren_b, fd_b;
    logic [ROWS-1:0][COLS-1:0] scr_b;
    logic [4:0]                rs_b;
    logic [COLS-1:0]           col_b;

    tetris_display_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL(A_D), .BLANK(A_B)) u_a (
        .clk(clk), .reset(rst_a), .enable(en_a), .screen(scr_a),
        .row_sel(rs_a), .row_en(ren_a), .col_data(col_a), .frame_done(fd_a)
    );

    tetris_display_scan #(.ROWS(ROWS), .COLS(COLS), .DWELL(B_D), .BLANK(B_B)) u_b (
        .clk(clk), .reset(rst_b), .enable(en_b), .screen(scr_b),
        .row_sel(rs_b), .row_en(ren_b), .col_data(col_b), .frame_done(fd_b)
    );

    typedef struct packed {
        logic [4:0]  row;
        logic        en;
        logic [9:0]  col;
        logic        fd;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } vec_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    out_t   sb_q[$];
    out_t   obs[0:1023];
    vec_t   tbl[$];
    int     cyc;
    int     m_t;
    bit     m_rst;
    out_t   p1, p2;
    logic [ROWS-1:0][COLS-1:0] m_snap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame-position model: t=0 is SNAP, then each row is BLANK cycles dark and DWELL lit.
    function automatic out_t expect_at(input int t, input logic [ROWS-1:0][COLS-1:0] snap);
        out_t e;
        int   k, p;
        e = '0;
        if (t == 0) begin
            e.fd = 1'b1;
        end else begin
            k     = (t - 1) / (A_D + A_B);
            p     = (t - 1) % (A_D + A_B);
            e.row = 5'(k);
            e.en  = (p >= A_B);
            if (e.en) e.col = snap[k];
        end
        return e;
    endfunction

    task automatic step_a();
        out_t e, a;
        int   nt;
        if (m_rst || !en_a || m_t == A_PER - 1) nt = 0;
        else nt = m_t + 1;
        if (!m_rst && m_t == 0) m_snap = scr_a;
        sb_q.push_back(expect_at(nt, m_snap));
        @(posedge clk);
        @(negedge clk);
        cyc++;
        m_t   = nt;
        m_rst = 1'b0;
        a     = '{row: rs_a, en: ren_a, col: col_a, fd: fd_a};
        if (cyc >= 0 && cyc < 1024) obs[cyc] = a;
        e = sb_q.pop_front();
        chk($sformatf("sb@%0d", cyc), 32'(a), 32'(e));
        if (a.en && !p1.en)
            chk($sformatf("blank_before_row%0d@%0d", a.row, cyc),
                {29'd0, p1.col == '0, p1.row == a.row, p2.en || p2.fd}, 32'h7);
        p2 = p1;
        p1 = a;
    endtask

    task automatic add(input int c, input int row, input bit en, input int col, input bit fd);
        vec_t v;
        v.cyc = c;
        v.o   = '{row: 5'(row), en: en, col: 10'(col), fd: fd};
        tbl.push_back(v);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int good[ROWS];
        int en_total, period, c;

        add(0, 0, 0, 'h000, 1);   add(1, 0, 0, 'h000, 0);
        add(2, 0, 1, 'h3FF, 0);   add(5, 0, 1, 'h3FF, 0);
        add(6, 1, 0, 'h000, 0);   add(7, 1, 1, 'h000, 0);
        add(96, 19, 0, 'h000, 0); add(100, 19, 1, 'h000, 0);
        add(101, 0, 0, 'h000, 1); add(118, 3, 1, 'h000, 0);
        add(128, 5, 1, 'h000, 0); add(229, 5, 1, 'h155, 0);
        add(342, 0, 0, 'h000, 1); add(345, 0, 0, 'h000, 1);
        add(346, 0, 0, 'h000, 0); add(347, 0, 1, 'h3FF, 0);
        add(408, 12, 1, 'h000, 0); add(409, 0, 0, 'h000, 1);
        add(411, 0, 1, 'h3FF, 0); add(510, 0, 0, 'h000, 1);

        rst_a = 1'b1; en_a = 1'b1; scr_a = '0; scr_a[0] = 10'h3FF;
        rst_b = 1'b1; en_b = 1'b0; scr_b = '0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("reset_row_sel", 32'(rs_a), 32'd0);
        chk("reset_row_en", 32'(ren_a), 32'd0);
        chk("reset_col_data", 32'(col_a), 32'd0);
        chk("reset_frame_done", 32'(fd_a), 32'd0);

        rst_a = 1'b0; cyc = -1; m_t = 0; m_rst = 1'b1; m_snap = '0; p1 = '0; p2 = '0;
        while (cyc < 302) begin
            if (cyc == 118) scr_a[5] = 10'h155;
            step_a();
        end
        while (cyc < 341) step_a();
        en_a = 1'b0;
        while (cyc < 345) step_a();
        en_a = 1'b1;
        while (cyc < 408) step_a();

        #2 rst_a = 1'b1;
        #1;
        chk("async_row_en", 32'(ren_a), 32'd0);
        chk("async_col_data", 32'(col_a), 32'd0);
        chk("async_row_sel", 32'(rs_a), 32'd0);
        chk("async_frame_done", 32'(fd_a), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("held_reset_row_en", 32'(ren_a), 32'd0);
        rst_a = 1'b0; m_rst = 1'b1; p1 = '0; p2 = '0;
        while (cyc < 512) step_a();

        foreach (tbl[i])
            chk($sformatf("tbl@%0d", tbl[i].cyc), 32'(obs[tbl[i].cyc]), 32'(tbl[i].o));

        for (int r = 0; r < ROWS; r++) begin
            scr_b[r] = (r % 2 == 0) ? 10'h2AA : 10'h155;
            good[r]  = 0;
        end
        en_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("b_first_frame_done", 32'(fd_b), 32'd1);
        en_total = 0;
        period   = -1;
        c        = 0;
        while (period < 0 && c < B_PER + 100) begin
            @(posedge clk); @(negedge clk);
            c++;
            if (fd_b) period = c;
            else if (ren_b) begin
                en_total++;
                if (col_b == ((rs_b % 2 == 0) ? 10'h2AA : 10'h155) && rs_b < ROWS)
                    good[rs_b]++;
            end
        end
        chk("b_frame_period", 32'(period), 32'(B_PER));
        chk("b_lit_cycles", 32'(en_total), 32'(ROWS * B_D));
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("b_row%0d_dwell", r), 32'(good[r]), 32'(B_D));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
